// File: rtl/ft245_pkg.sv
// Shared FT245 TX framing definitions: header layout, sync byte and arbiter FSM states.
// The host-side parser decodes headers with the same offsets.
package ft245_pkg;

    localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;

    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_SEQ_LSB  = 16;
    localparam int HDR_LEN_LSB  = 8;
    localparam int HDR_ID_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } tx_state_e;

    // Bits [7:4] stay zero; they are reserved for the host parser.
    function automatic logic [31:0] mk_header(input logic [7:0] sync,
                                              input logic [7:0] seq,
                                              input logic [7:0] len,
                                              input logic [3:0] id);
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_SYNC_LSB +: 8] = sync;
        hdr[HDR_SEQ_LSB  +: 8] = seq;
        hdr[HDR_LEN_LSB  +: 8] = len;
        hdr[HDR_ID_LSB   +: 4] = id;
        return hdr;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above the pointer, wrapping at N.
// The pointer itself is owned by the caller.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [3:0]   i_ptr,
    output logic [N-1:0] o_grant,
    output logic [3:0]   o_idx,
    output logic         o_any
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [4:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int off = 0; off < N; off++) begin
            w_pos = {1'b0, i_ptr} + 5'(off);
            if (w_pos >= 5'(N))
                w_pos = w_pos - 5'(N);
            if (!o_any && i_req[w_pos[IW-1:0]]) begin
                o_any                  = 1'b1;
                o_idx                  = w_pos[3:0];
                o_grant[w_pos[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_stream_arbiter.sv
// Round-robin sharing of the core_ft245 TX write port: each grant emits one header word
// followed by up to MAX_BURST payload words, stalling on tx_full without loss.
module tx_stream_arbiter
    import ft245_pkg::*;
#(
    parameter int         N_CH      = 4,
    parameter int         MAX_BURST = 64,
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [N_CH-1:0]       ch_valid,
    input  logic [N_CH-1:0][31:0] ch_data,
    input  logic [N_CH-1:0]       ch_last,
    output logic [N_CH-1:0]       ch_ready,
    input  logic                  tx_full,
    output logic                  tx_write,
    output logic [31:0]           tx_data,
    output logic [3:0]            grant_id,
    output logic                  busy
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    if (N_CH < 2 || N_CH > 16) begin : g_bad_nch
        $error("tx_stream_arbiter: N_CH must be in 2..16 (grant_id is 4 bits)");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("tx_stream_arbiter: MAX_BURST must be in 1..255");
    end

    tx_state_e       r_state;
    logic [3:0]      r_ptr;
    logic [7:0]      r_cnt;
    logic [7:0]      r_seq [N_CH];

    logic [N_CH-1:0] w_unused_grant;
    logic [3:0]      w_idx;
    logic            w_any;
    logic [IW-1:0]   w_gidx;
    logic            w_xfer;
    logic            w_end;
    logic [3:0]      w_ptr_nxt;

    rr_arbiter #(.N(N_CH)) u_rr (
        .i_req  (ch_valid),
        .i_ptr  (r_ptr),
        .o_grant(w_unused_grant),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_gidx    = grant_id[IW-1:0];
    assign w_xfer    = (r_state == ST_DATA) && !tx_full && ch_valid[w_gidx];
    assign w_end     = ch_last[w_gidx] || (r_cnt == 8'(MAX_BURST - 1));
    assign w_ptr_nxt = (grant_id == 4'(N_CH - 1)) ? 4'd0 : grant_id + 4'd1;

    // Ready is only offered when the word can go straight into the TX FIFO.
    always_comb begin
        ch_ready = '0;
        if (r_state == ST_DATA && !tx_full)
            ch_ready[w_gidx] = 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            tx_write <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            for (int i = 0; i < N_CH; i++)
                r_seq[i] <= '0;
        end else begin
            tx_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        grant_id <= w_idx;
                        busy     <= 1'b1;
                        r_state  <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!tx_full) begin
                        tx_write <= 1'b1;
                        tx_data  <= mk_header(SYNC_WORD, r_seq[w_gidx], 8'(MAX_BURST), grant_id);
                        r_cnt    <= '0;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        tx_write <= 1'b1;
                        tx_data  <= ch_data[w_gidx];
                        r_cnt    <= r_cnt + 8'd1;
                        if (w_end) begin
                            r_state       <= ST_IDLE;
                            busy          <= 1'b0;
                            r_ptr         <= w_ptr_nxt;
                            r_seq[w_gidx] <= r_seq[w_gidx] + 8'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
